pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC of the 5-stage RISC-V pipeline.
- Detects load-use hazards and inserts one bubble into ID/EX.
- Flushes IF/ID on a taken branch, which is resolved in ID.
- Freezes the front of the pipeline while a multi-cycle EX operation (mul/div) occupies EX for MC_LAT cycles, feeding bubbles into EX/MEM.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
MC_LAT, 4, total cycles a multi-cycle op occupies EX; legal range 2..255
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  in  1  clock, all state changes on rising edge
rst_i  in  1  synchronous reset, active-low
IDEX_MemRead_i  in  1  instruction currently in ID/EX is a load
IDEX_RDaddr_i  in  5  destination register of the ID/EX instruction
IDEX_MultiCycle_i  in  1  instruction currently in ID/EX needs MC_LAT EX cycles
IFID_RS1addr_i  in  5  rs1 of the instruction in ID
IFID_RS2addr_i  in  5  rs2 of the instruction in ID
IFID_RS1use_i  in  1  ID instruction reads rs1
IFID_RS2use_i  in  1  ID instruction reads rs2
Branch_taken_i  in  1  branch in ID resolved taken this cycle
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID load enable
IFIDFlush_o  out  1  IF/ID cleared to NOP on this edge
IDEXWrite_o  out  1  ID/EX load enable
IDEXBubble_o  out  1  ID/EX control bits (RegWrite, MemtoReg, MemRead, MemWrite) zeroed on this edge
EXMEMBubble_o  out  1  EX/MEM control bits zeroed on this edge
StallCnt_o  out  CNT_W  cycles with PCWrite_o=0 since reset, saturating

Behaviour:
- State register with two states, RUN and MC_BUSY, plus an 8-bit down-counter mc_cnt and the StallCnt register. All update on the clk_i rising edge.
- Outputs are combinational from state and inputs.
- While rst_i=0, outputs take idle values:
  - PCWrite, IFIDWrite, IDEXWrite = 1.
  - IFIDFlush, IDEXBubble, EXMEMBubble = 0.
- Reset edge action: state<=RUN, mc_cnt<=0, StallCnt<=0.
- A reset asserted mid-stall aborts the stall; RUN applies on the first cycle after reset release.
- Hazard term: load_use = IDEX_MemRead_i & (IDEX_RDaddr_i!=0) & ((IFID_RS1use_i & RS1 match) | (IFID_RS2use_i & RS2 match)).
- Priority, highest first: multi-cycle stall > load-use > branch flush.
- RUN with IDEX_MultiCycle_i=1:
  - PCWrite=IFIDWrite=IDEXWrite=0, EXMEMBubble=1.
  - Next state MC_BUSY, mc_cnt<=MC_LAT-2.
  - load_use and Branch_taken_i are ignored.
- MC_BUSY with mc_cnt!=0: same stall outputs; mc_cnt decrements. All hazard inputs are ignored, and IDEX_MultiCycle_i is not re-sampled.
- MC_BUSY with mc_cnt==0 (release cycle):
  - EXMEMBubble=0, so the result enters EX/MEM.
  - Next state RUN.
  - Other outputs follow the RUN rules below with IDEX_MultiCycle_i treated as 0.
- Resulting occupancy: the multi-cycle op holds EX for exactly MC_LAT cycles, and the front end stalls MC_LAT-1 cycles.
- RUN (or release cycle) with load_use=1:
  - PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEXBubble=1.
  - IFIDFlush=0 even if Branch_taken_i=1; the branch re-resolves next cycle with correct operands.
- RUN (or release cycle) with no load_use and Branch_taken_i=1: IFIDFlush=1, PCWrite=1, IFIDWrite=1, IDEXWrite=1.
- Otherwise, all enables are 1 and all bubbles/flush are 0.
- rd=x0 never causes a load-use stall.
- StallCnt increments on every non-reset edge where PCWrite_o=0. At all-ones it holds, with no wrap.
- Back-to-back multi-cycle ops: after the release cycle the next op enters ID/EX. It is detected in RUN on the following cycle, with no idle gap required.

Test Plan:
1. Load-use: IDEX load with rd=x5, ID instruction rs1=x5 use1=1 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for exactly 1 cycle. StallCnt 0->1. Repeat with rd=x0 -> no stall.
2. Branch: Branch_taken_i=1, no hazard -> IFIDFlush=1 for 1 cycle, PCWrite=1. Branch_taken_i=1 together with load_use -> IFIDFlush=0, stall only.
3. Multi-cycle op with MC_LAT=4: IDEX_MultiCycle_i=1 -> stall outputs and EXMEMBubble=1 for 3 cycles, release on the 4th with EXMEMBubble=0. StallCnt=3. Rerun at MC_LAT=2 -> 1 stall cycle.
4. Priority: Branch_taken_i=1 and load_use pulsed during MC_BUSY -> no flush or bubble. Load_use present on the release cycle -> IDEXBubble=1 on that cycle.
5. Reset mid-op: rst_i=0 in 2nd MC_BUSY cycle -> idle outputs while low. After release, state is RUN, StallCnt=0, and no residual stall.
6. Saturation with CNT_W=4: hold load_use for 20 cycles -> StallCnt reaches 15 and stays.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline: load-use bubbles, branch flush in ID,
// multi-cycle EX freeze and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic             IDEX_MultiCycle_i,
    input  logic [4:0]       IFID_RS1addr_i,
    input  logic [4:0]       IFID_RS2addr_i,
    input  logic             IFID_RS1use_i,
    input  logic             IFID_RS2use_i,
    input  logic             Branch_taken_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             IDEXWrite_o,
    output logic             IDEXBubble_o,
    output logic             EXMEMBubble_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    typedef enum logic [0:0] {StRun, StMcBusy} state_e;

    // Entry cycle in RUN already counts as one EX cycle, release cycle as another.
    localparam logic [7:0] McInit = 8'(MC_LAT - 2);

    state_e           state_q, state_d;
    logic [7:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             rs1_hit, rs2_hit, load_use, mc_stall;

    always_comb begin
        rs1_hit  = IFID_RS1use_i && (IFID_RS1addr_i == IDEX_RDaddr_i);
        rs2_hit  = IFID_RS2use_i && (IFID_RS2addr_i == IDEX_RDaddr_i);
        load_use = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) && (rs1_hit || rs2_hit);
    end

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        mc_stall = 1'b0;
        unique case (state_q)
            StRun: begin
                if (IDEX_MultiCycle_i) begin
                    mc_stall = 1'b1;
                    state_d  = StMcBusy;
                    mc_cnt_d = McInit;
                end
            end
            StMcBusy: begin
                if (mc_cnt_q != 8'd0) begin
                    mc_stall = 1'b1;
                    mc_cnt_d = mc_cnt_q - 8'd1;
                end else begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        PCWrite_o     = 1'b1;
        IFIDWrite_o   = 1'b1;
        IFIDFlush_o   = 1'b0;
        IDEXWrite_o   = 1'b1;
        IDEXBubble_o  = 1'b0;
        EXMEMBubble_o = 1'b0;
        if (rst_i) begin
            if (mc_stall) begin
                PCWrite_o     = 1'b0;
                IFIDWrite_o   = 1'b0;
                IDEXWrite_o   = 1'b0;
                EXMEMBubble_o = 1'b1;
            end else if (load_use) begin
                // A taken branch here used stale operands; it re-resolves after the bubble.
                PCWrite_o    = 1'b0;
                IFIDWrite_o  = 1'b0;
                IDEXBubble_o = 1'b1;
            end else if (Branch_taken_i) begin
                IFIDFlush_o = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PCWrite_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign StallCnt_o = stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= StRun;
            mc_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controller instances (MC_LAT=4/CNT_W=16 and MC_LAT=2/CNT_W=4) share
// stimulus; a cycle-level reference model queues expected outputs for a decoupled monitor.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        flush;
        logic        idex;
        logic        idbub;
        logic        exbub;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } exp_pair_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       memread = 1'b0, mc = 1'b0, u1 = 1'b0, u2 = 1'b0, br = 1'b0;
    logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;

    logic        pc_a, ifid_a, flush_a, idex_a, idbub_a, exbub_a;
    logic [15:0] cnt_a;
    logic        pc_b, ifid_b, flush_b, idex_b, idbub_b, exbub_b;
    logic [3:0]  cnt_b;

    exp_pair_t exp_q[$];
    int        total = 0;
    int        bad = 0;
    bit        stim_done = 0;

    // Model state per instance: remaining EX cycles of the op in flight, stall count.
    int rem[2] = '{0, 0};
    int scnt[2] = '{0, 0};
    int lat[2] = '{4, 2};
    int cmax[2] = '{65535, 15};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MC_LAT(4), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_i),
        .IDEX_MemRead_i(memread), .IDEX_RDaddr_i(rd), .IDEX_MultiCycle_i(mc),
        .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
        .IFID_RS1use_i(u1), .IFID_RS2use_i(u2), .Branch_taken_i(br),
        .PCWrite_o(pc_a), .IFIDWrite_o(ifid_a), .IFIDFlush_o(flush_a),
        .IDEXWrite_o(idex_a), .IDEXBubble_o(idbub_a), .EXMEMBubble_o(exbub_a),
        .StallCnt_o(cnt_a)
    );

    pipeline_hazard_ctrl #(.MC_LAT(2), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_i),
        .IDEX_MemRead_i(memread), .IDEX_RDaddr_i(rd), .IDEX_MultiCycle_i(mc),
        .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
        .IFID_RS1use_i(u1), .IFID_RS2use_i(u2), .Branch_taken_i(br),
        .PCWrite_o(pc_b), .IFIDWrite_o(ifid_b), .IFIDFlush_o(flush_b),
        .IDEXWrite_o(idex_b), .IDEXBubble_o(idbub_b), .EXMEMBubble_o(exbub_b),
        .StallCnt_o(cnt_b)
    );

    function automatic exp_t model_step(input int k);
        exp_t e;
        bit   lu, stall_mc, release_c;
        e = '{pc: 1'b1, ifid: 1'b1, flush: 1'b0, idex: 1'b1, idbub: 1'b0, exbub: 1'b0,
              cnt: 16'(scnt[k])};
        if (!rst_i) begin
            rem[k]  = 0;
            scnt[k] = 0;
            return e;
        end
        lu = memread && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        stall_mc  = 0;
        release_c = 0;
        if (rem[k] > 1) begin
            stall_mc = 1;
            rem[k]   = rem[k] - 1;
        end else if (rem[k] == 1) begin
            release_c = 1;
            rem[k]    = 0;
        end else if (mc) begin
            stall_mc = 1;
            rem[k]   = lat[k] - 1;
        end
        if (stall_mc) begin
            e.pc = 0; e.ifid = 0; e.idex = 0; e.exbub = 1;
        end else if (lu) begin
            e.pc = 0; e.ifid = 0; e.idbub = 1;
        end else if (br) begin
            e.flush = 1;
        end
        if (!e.pc && scnt[k] < cmax[k]) scnt[k] = scnt[k] + 1;
        return e;
    endfunction

    task automatic drive(input bit r, input bit mr, input int d, input bit m, input int a1,
                         input int a2, input bit e1, input bit e2, input bit b);
        exp_pair_t p;
        @(posedge clk);
        #1;
        rst_i = r; memread = mr; rd = 5'(d); mc = m; rs1 = 5'(a1); rs2 = 5'(a2);
        u1 = e1; u2 = e2; br = b;
        p.a = model_step(0);
        p.b = model_step(1);
        exp_q.push_back(p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input exp_t act, input exp_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t actual pc/ifid/fl/idex/idb/exb=%b%b%b%b%b%b cnt=%0d required %b%b%b%b%b%b cnt=%0d",
                     name, $time, act.pc, act.ifid, act.flush, act.idex, act.idbub, act.exbub,
                     act.cnt, req.pc, req.ifid, req.flush, req.idex, req.idbub, req.exbub,
                     req.cnt);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled mid-cycle.
    initial begin
        exp_pair_t p;
        exp_t      act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                p   = exp_q.pop_front();
                act = '{pc: pc_a, ifid: ifid_a, flush: flush_a, idex: idex_a, idbub: idbub_a,
                        exbub: exbub_a, cnt: cnt_a};
                check("lat4_cnt16", act, p.a);
                act = '{pc: pc_b, ifid: ifid_b, flush: flush_b, idex: idex_b, idbub: idbub_b,
                        exbub: exbub_b, cnt: {12'd0, cnt_b}};
                check("lat2_cnt4", act, p.b);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on rs1, then rd=x0 and rs2 hit
        drive(1, 1, 5, 0, 5, 0, 1, 0, 0);
        idle(1);
        drive(1, 1, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 1, 7, 0, 1, 7, 0, 1, 0);
        drive(1, 1, 7, 0, 1, 7, 0, 0, 0);
        // branch alone, then branch with load-use
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 3, 0, 3, 0, 1, 0, 1);
        idle(1);
        // multi-cycle op held in ID/EX until release
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // hazards during busy, load-use on release
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 4, 1, 4, 0, 1, 0, 1);
        drive(1, 1, 4, 1, 4, 0, 1, 0, 1);
        drive(1, 1, 4, 0, 4, 0, 1, 0, 1);
        idle(2);
        // back-to-back multi-cycle ops
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);
        // reset in the second busy cycle
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 1);
        drive(0, 1, 2, 1, 2, 0, 1, 0, 0);
        idle(3);
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 59) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0);
        end
        // saturation: 20 cycles of load-use after a fresh reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 1, 9, 0, 9, 9, 1, 1, 0);
        idle(2);
        stim_done = 1;
    end

    initial begin
        int guard;
        guard = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1);
    end

endmodule
